// File: rtl/button_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer feeding a 4-state qualify FSM that
// emits press/release/long-press pulses and a wrapping press counter.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned LONG_CYC     = 50_000_000,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic       ck,
   input  logic       r,
   input  logic       btn,
   output logic       level,
   output logic       press,
   output logic       rel,
   output logic       long,
   output logic [7:0] npress
);

   typedef enum logic [1:0] {IDLE, ARM, PRESSED, REL_ARM} state_t;

   localparam logic [25:0] DEB_M1  = 26'(DEBOUNCE_CYC - 1);
   localparam logic [25:0] DEB_CYC = 26'(DEBOUNCE_CYC);
   localparam logic [25:0] LONG_M1 = 26'(LONG_CYC - 1);

   state_t      r_state, w_state_nxt;
   logic        r_sync1, r_sync2;
   logic        w_s;
   logic [25:0] r_dcnt, w_dcnt_nxt;
   logic [25:0] r_lcnt, w_lcnt_nxt;
   logic        r_long_done, w_long_done_nxt;
   logic        r_press, w_press_nxt;
   logic        r_rel, w_rel_nxt;
   logic        r_long, w_long_nxt;
   logic [7:0]  r_npress, w_npress_nxt;
   logic        w_hold;

   // Synchronizer resets to the pin's idle level so a held button re-qualifies.
   always_ff @(posedge ck) begin
      if (r) begin
         r_sync1 <= ACTIVE_LOW;
         r_sync2 <= ACTIVE_LOW;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2 ^ ACTIVE_LOW;

   always_ff @(posedge ck) begin
      if (r) begin
         r_state     <= IDLE;
         r_dcnt      <= '0;
         r_lcnt      <= '0;
         r_long_done <= 1'b0;
         r_press     <= 1'b0;
         r_rel       <= 1'b0;
         r_long      <= 1'b0;
         r_npress    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_dcnt      <= w_dcnt_nxt;
         r_lcnt      <= w_lcnt_nxt;
         r_long_done <= w_long_done_nxt;
         r_press     <= w_press_nxt;
         r_rel       <= w_rel_nxt;
         r_long      <= w_long_nxt;
         r_npress    <= w_npress_nxt;
      end
   end

   assign w_hold = ((r_state == PRESSED) || (r_state == REL_ARM)) && !r_long_done;

   always_comb begin
      w_state_nxt     = r_state;
      w_dcnt_nxt      = r_dcnt;
      w_lcnt_nxt      = r_lcnt;
      w_long_done_nxt = r_long_done;
      w_press_nxt     = 1'b0;
      w_rel_nxt       = 1'b0;
      w_long_nxt      = 1'b0;
      w_npress_nxt    = r_npress;

      // Hold timer keeps running through release bounces; saturates once long fires.
      if (w_hold) begin
         if (r_lcnt == LONG_M1) begin
            w_long_nxt      = 1'b1;
            w_long_done_nxt = 1'b1;
         end else begin
            w_lcnt_nxt = r_lcnt + 26'd1;
         end
      end

      case (r_state)
         IDLE: begin
            if (w_s) begin
               w_state_nxt = ARM;
               w_dcnt_nxt  = 26'd1;
            end
         end
         ARM: begin
            if (!w_s) begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == DEB_M1) begin
               w_state_nxt     = PRESSED;
               w_dcnt_nxt      = '0;
               w_press_nxt     = 1'b1;
               w_npress_nxt    = r_npress + 8'd1;
               w_lcnt_nxt      = DEB_CYC;
               w_long_done_nxt = 1'b0;
            end else begin
               w_dcnt_nxt = r_dcnt + 26'd1;
            end
         end
         PRESSED: begin
            if (!w_s) begin
               w_state_nxt = REL_ARM;
               w_dcnt_nxt  = 26'd1;
            end
         end
         REL_ARM: begin
            if (w_s) begin
               w_state_nxt = PRESSED;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == DEB_M1) begin
               // Release wins over a long press qualified on the same edge.
               w_state_nxt     = IDLE;
               w_dcnt_nxt      = '0;
               w_rel_nxt       = 1'b1;
               w_long_nxt      = 1'b0;
               w_long_done_nxt = 1'b0;
            end else begin
               w_dcnt_nxt = r_dcnt + 26'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign level  = (r_state == PRESSED) || (r_state == REL_ARM);
   assign press  = r_press;
   assign rel    = r_rel;
   assign long   = r_long;
   assign npress = r_npress;

endmodule
